seq_adder_nbit: RTL and testbench

Multi-cycle, parametrised unsigned adder. It adds two WIDTH-bit operands plus a carry-in, processing CHUNK bits per clock through a single CHUNK-bit combinational slice. A start/busy/done handshake controls it, and the result is held in registers. It is the sequential, area-reduced successor to the fixed 4-bit combinational adder, intended for wide datapaths where one narrow adder is reused over several cycles.

---
 rtl/seq_adder_pkg.sv | 19 +
 rtl/adder_nbit.sv | 14 +
 rtl/seq_adder_nbit.sv | 112 +++++++++++
 tb/tb_seq_adder_nbit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_adder_pkg.sv
// Shared types and defaults for the multi-cycle chunked adder.
// The optional SIGNED_OVF_EN build adds a signed-overflow flag in the top level.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  // Chunk counter width; a single-chunk adder still needs a one-bit counter
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_nbit.sv
// Combinational BITS-wide ripple slice reused once per clock by seq_adder_nbit.
module adder_nbit #(
  parameter int BITS = 4
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            carry_in,
  output logic [BITS-1:0] sum,
  output logic            carry_out
);

  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{BITS{1'b0}}, carry_in};

endmodule

// File: rtl/seq_adder_nbit.sv
// Sequential WIDTH-bit adder that walks CHUNK bits per clock through one narrow slice.
// Define SIGNED_OVF_EN to add the signed_ovf output.
module seq_adder_nbit
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SIGNED_OVF_EN
  output logic             signed_ovf,
`endif
  output logic             overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = cnt_width(N);

  state_t state, next_state;

  logic [WIDTH-1:0] a_reg, b_reg;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] a_chunk, b_chunk, chunk_sum;
  logic             chunk_cout;
  logic             accept;
  logic             last;

  assign accept  = start && (state != ADD);
  assign last    = (cnt == CW'(N - 1));
  assign a_chunk = a_reg[cnt*CHUNK +: CHUNK];
  assign b_chunk = b_reg[cnt*CHUNK +: CHUNK];

  adder_nbit #(.BITS(CHUNK)) u_slice (
    .a         (a_chunk),
    .b         (b_chunk),
    .carry_in  (carry),
    .sum       (chunk_sum),
    .carry_out (chunk_cout)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = ADD;
      end
      ADD: begin
        busy = 1'b1;
        if (last) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = start ? ADD : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The counter is parked on the last chunk after a sum; only an accepted start rewinds it
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      carry      <= 1'b0;
      cnt        <= '0;
      sum        <= '0;
      overflow   <= 1'b0;
`ifdef SIGNED_OVF_EN
      signed_ovf <= 1'b0;
`endif
    end else if (accept) begin
      a_reg      <= a;
      b_reg      <= b;
      carry      <= carry_in;
      cnt        <= '0;
      sum        <= '0;
      overflow   <= 1'b0;
`ifdef SIGNED_OVF_EN
      signed_ovf <= 1'b0;
`endif
    end else if (state == ADD) begin
      sum[cnt*CHUNK +: CHUNK] <= chunk_sum;
      carry                   <= chunk_cout;
      if (last) begin
        overflow   <= chunk_cout;
`ifdef SIGNED_OVF_EN
        signed_ovf <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                      (chunk_sum[CHUNK-1] != a_reg[WIDTH-1]);
`endif
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_adder_nbit.sv
// Directed self-checking bench: a 16/4 instance for handshake and arithmetic,
// plus a 4/2 instance swept exhaustively.
module tb_seq_adder_nbit;

  logic        clk;
  logic        n_rst;

  logic        start;
  logic [15:0] a, b;
  logic        carry_in;
  logic        busy, done, overflow;
  logic [15:0] sum;

  logic        s_start;
  logic [3:0]  s_a, s_b;
  logic        s_carry_in;
  logic        s_busy, s_done, s_overflow;
  logic [3:0]  s_sum;

`ifdef SIGNED_OVF_EN
  logic        signed_ovf;
  logic        s_signed_ovf;
`endif

  int pass_cnt  = 0;
  int check_cnt = 0;

  seq_adder_nbit #(.WIDTH(16), .CHUNK(4)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .carry_in   (carry_in),
    .busy       (busy),
    .done       (done),
    .sum        (sum),
`ifdef SIGNED_OVF_EN
    .signed_ovf (signed_ovf),
`endif
    .overflow   (overflow)
  );

  seq_adder_nbit #(.WIDTH(4), .CHUNK(2)) dut_s (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (s_start),
    .a          (s_a),
    .b          (s_b),
    .carry_in   (s_carry_in),
    .busy       (s_busy),
    .done       (s_done),
    .sum        (s_sum),
`ifdef SIGNED_OVF_EN
    .signed_ovf (s_signed_ovf),
`endif
    .overflow   (s_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at posedge+1; returns at posedge+1 of the done cycle, lat=-1 on timeout
  task automatic run_big(input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tc, output int lat);
    a = ta; b = tb_v; carry_in = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; start = 1'b0; a = '0; b = '0; carry_in = 1'b0;
    s_start = 1'b0; s_a = '0; s_b = '0; s_carry_in = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_cnt++;
    if ({busy, done, overflow, sum} !== 19'h0)
      $display("[TB] FAIL reset_state: got busy=%b done=%b ovf=%b sum=%h, want all 0", busy, done, overflow, sum);
    else pass_cnt++;
    n_rst = 1'b1;
    @(posedge clk); #1;
    a = 16'hFFFF; b = 16'hFFFF; carry_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check_cnt++;
    if (busy !== 1'b1 || sum !== 16'h000E)
      $display("[TB] FAIL reset_pre: got busy=%b sum=%h, want busy=1 sum=000e", busy, sum);
    else pass_cnt++;
    n_rst = 1'b0;
    #1;
    check_cnt++;
    if ({busy, done, overflow, sum} !== 19'h0)
      $display("[TB] FAIL reset_mid_add: got busy=%b done=%b ovf=%b sum=%h, want all 0", busy, done, overflow, sum);
    else pass_cnt++;
    @(negedge clk);
    n_rst = 1'b1;
    begin
      int seen = 0;
      for (int k = 0; k < 8; k++) begin
        @(posedge clk); #1;
        if (done || busy) seen++;
      end
      check_cnt++;
      if (seen != 0)
        $display("[TB] FAIL reset_stays_idle: got %0d active cycles, want 0", seen);
      else pass_cnt++;
    end
  endtask

  task automatic test_basic();
    int lat;
    run_big(16'h1234, 16'h4321, 1'b0, lat);
    check_cnt++;
    if (lat != 4) $display("[TB] FAIL basic_latency: got %0d, want 4", lat);
    else pass_cnt++;
    check_cnt++;
    if (sum !== 16'h5555 || overflow !== 1'b0 || busy !== 1'b0)
      $display("[TB] FAIL basic_result: got sum=%h ovf=%b busy=%b, want 5555 0 0", sum, overflow, busy);
    else pass_cnt++;
    @(posedge clk); #1;
    check_cnt++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("[TB] FAIL basic_pulse: got done=%b busy=%b, want 0 0", done, busy);
    else pass_cnt++;
  endtask

  task automatic test_ripple();
    int lat;
    run_big(16'hFFFF, 16'h0000, 1'b1, lat);
    check_cnt++;
    if (lat != 4 || sum !== 16'h0000 || overflow !== 1'b1)
      $display("[TB] FAIL ripple: got lat=%0d sum=%h ovf=%b, want 4 0000 1", lat, sum, overflow);
    else pass_cnt++;
`ifdef SIGNED_OVF_EN
    check_cnt++;
    if (signed_ovf !== 1'b0)
      $display("[TB] FAIL ripple_signed: got %b, want 0", signed_ovf);
    else pass_cnt++;
`endif
  endtask

  task automatic test_signed();
    int lat;
    run_big(16'h7FFF, 16'h0001, 1'b0, lat);
    check_cnt++;
    if (lat != 4 || sum !== 16'h8000 || overflow !== 1'b0)
      $display("[TB] FAIL signed_sum: got lat=%0d sum=%h ovf=%b, want 4 8000 0", lat, sum, overflow);
    else pass_cnt++;
`ifdef SIGNED_OVF_EN
    check_cnt++;
    if (signed_ovf !== 1'b1)
      $display("[TB] FAIL signed_ovf: got %b, want 1", signed_ovf);
    else pass_cnt++;
`endif
  endtask

  task automatic test_ignore_start();
    int lat;
    a = 16'h1111; b = 16'h2222; carry_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 16'hAAAA; b = 16'h5555; carry_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 3; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check_cnt++;
    if (lat != 4 || sum !== 16'h3333 || overflow !== 1'b0)
      $display("[TB] FAIL ignore_start: got lat=%0d sum=%h ovf=%b, want 4 3333 0", lat, sum, overflow);
    else pass_cnt++;
  endtask

  task automatic test_hold();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    check_cnt++;
    if (sum !== 16'h3333 || done !== 1'b0 || busy !== 1'b0)
      $display("[TB] FAIL sum_hold: got sum=%h done=%b busy=%b, want 3333 0 0", sum, done, busy);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int hits[$];
    int bad_sum = 0;
    a = 16'h0101; b = 16'h0202; carry_in = 1'b0; start = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (done) begin
        hits.push_back(k);
        if (sum !== 16'h0303) bad_sum++;
      end
    end
    start = 1'b0;
    check_cnt++;
    if (hits.size() != 3 || hits[0] != 4 || hits[1] != 9 || hits[2] != 14)
      $display("[TB] FAIL back_to_back_period: got %0d pulses first=%0d, want 3 pulses at 4,9,14",
               hits.size(), (hits.size() > 0) ? hits[0] : -1);
    else pass_cnt++;
    check_cnt++;
    if (bad_sum != 0)
      $display("[TB] FAIL back_to_back_sum: got %0d wrong sums, want 0", bad_sum);
    else pass_cnt++;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sweep();
    int errs = 0;
    int lat;
    logic [8:0] v;
    logic [4:0] exp_v;
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      s_a = v[3:0]; s_b = v[7:4]; s_carry_in = v[8]; s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      lat = -1;
      for (int k = 1; k <= 10; k++) begin
        @(posedge clk); #1;
        if (s_done) begin
          lat = k;
          break;
        end
      end
      exp_v = {1'b0, v[3:0]} + {1'b0, v[7:4]} + {4'b0, v[8]};
      check_cnt++;
      if (lat != 2 || {s_overflow, s_sum} !== exp_v) begin
        errs++;
        if (errs <= 5)
          $display("[TB] FAIL sweep a=%h b=%h c=%b: got lat=%0d {ovf,sum}=%h, want lat=2 %h",
                   v[3:0], v[7:4], v[8], lat, {s_overflow, s_sum}, exp_v);
      end else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ripple();
    test_signed();
    test_ignore_start();
    test_hold();
    test_back_to_back();
    test_sweep();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
